// File: rtl/addsub_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : addsub_arbiter                                                |
// | Description : Round-robin arbiter sharing one add/subtract datapath        |
// |               between two valid/ready requesters; one op in flight.        |
// |               Optional macro ADDSUB_ARB_FLAGS_EN adds per-port result      |
// |               flags {carry, overflow, negative, zero}.                     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module addsub_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic             req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_data,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic             req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_data,
  output logic             busy
`ifdef ADDSUB_ARB_FLAGS_EN
  ,
  output logic [3:0]       rsp0_flags,
  output logic [3:0]       rsp1_flags
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             ptr_q, ptr_d;       // port holding priority in IDLE
  logic             owner_q, owner_d;   // port whose operation is in flight
  logic             op_q;
  logic [WIDTH-1:0] a_q, b_q, res_q;

  logic [1:0]       w_req_valid;
  logic [1:0]       w_rsp_ready;
  logic             w_grant;
  logic             w_accept;
  logic [WIDTH-1:0] w_b_eff;
  logic [WIDTH-1:0] w_sum;

  assign w_req_valid = {req1_valid, req0_valid};
  assign w_rsp_ready = {rsp1_ready, rsp0_ready};

  // Next-state, grant selection and priority rotation
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    w_grant  = ptr_q;
    w_accept = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (w_req_valid[ptr_q]) begin
          w_grant  = ptr_q;
          w_accept = 1'b1;
        end else if (w_req_valid[~ptr_q]) begin
          w_grant  = ~ptr_q;
          w_accept = 1'b1;
        end
        if (w_accept) begin
          owner_d = w_grant;
          state_d = EXEC;
        end
      end
      EXEC: state_d = RESP;
      RESP: begin
        // Early rsp_ready is harmless: only sampled here, in RESP
        if (w_rsp_ready[owner_q]) begin
          state_d = IDLE;
          ptr_d   = ~owner_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign req0_ready = w_accept & ~w_grant;
  assign req1_ready = w_accept &  w_grant;

  // Control state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      owner_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
    end
  end

  // Capture the granted port's operation on accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q <= 1'b0;
      a_q  <= '0;
      b_q  <= '0;
    end else if (w_accept) begin
      op_q <= w_grant ? req1_op : req0_op;
      a_q  <= w_grant ? req1_a  : req0_a;
      b_q  <= w_grant ? req1_b  : req0_b;
    end
  end

  // Subtract is a + ~b + 1 so one adder serves both operations
  assign w_b_eff = op_q ? ~b_q : b_q;

`ifdef ADDSUB_ARB_FLAGS_EN
  logic [WIDTH:0] w_sum_ext;
  logic [3:0]     w_flags;
  logic [3:0]     flags_q;

  assign w_sum_ext = {1'b0, a_q} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, op_q};
  assign w_sum     = w_sum_ext[WIDTH-1:0];
  // Overflow: operands of equal sign produce a result of the other sign
  assign w_flags   = {w_sum_ext[WIDTH],
                      (a_q[WIDTH-1] == w_b_eff[WIDTH-1]) && (w_sum[WIDTH-1] != a_q[WIDTH-1]),
                      w_sum[WIDTH-1],
                      (w_sum == '0)};

  // Flags registered alongside the result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q <= 4'd0;
    end else if (state_q == EXEC) begin
      flags_q <= w_flags;
    end
  end

  assign rsp0_flags = rsp0_valid ? flags_q : 4'd0;
  assign rsp1_flags = rsp1_valid ? flags_q : 4'd0;
`else
  assign w_sum = a_q + w_b_eff + {{(WIDTH-1){1'b0}}, op_q};
`endif

  // Result register, written in the single EXEC cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_q <= '0;
    end else if (state_q == EXEC) begin
      res_q <= w_sum;
    end
  end

  assign rsp0_valid = (state_q == RESP) && !owner_q;
  assign rsp1_valid = (state_q == RESP) &&  owner_q;
  assign rsp0_data  = rsp0_valid ? res_q : '0;
  assign rsp1_data  = rsp1_valid ? res_q : '0;
  assign busy       = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_addsub_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_addsub_arbiter                                             |
// | Description : Self-checking bench for addsub_arbiter: directed scenarios   |
// |               plus randomized traffic against a transaction-level model.   |
// |               Flag checks enabled when ADDSUB_ARB_FLAGS_EN is defined.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_addsub_arbiter;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       vld, op, rspr;
  logic [1:0][31:0] a, b;
  logic             req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy;
  logic [31:0]      rsp0_data, rsp1_data;
  logic [1:0]       rdy, rspv;
  logic [31:0]      dat [2];
`ifdef ADDSUB_ARB_FLAGS_EN
  logic [3:0]       rsp0_flags, rsp1_flags;
`endif

  assign rdy    = {req1_ready, req0_ready};
  assign rspv   = {rsp1_valid, rsp0_valid};
  assign dat[0] = rsp0_data;
  assign dat[1] = rsp1_data;

  addsub_arbiter #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(vld[0]), .req0_ready(req0_ready), .req0_op(op[0]),
    .req0_a(a[0]), .req0_b(b[0]),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rspr[0]), .rsp0_data(rsp0_data),
    .req1_valid(vld[1]), .req1_ready(req1_ready), .req1_op(op[1]),
    .req1_a(a[1]), .req1_b(b[1]),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rspr[1]), .rsp1_data(rsp1_data),
    .busy(busy)
`ifdef ADDSUB_ARB_FLAGS_EN
    , .rsp0_flags(rsp0_flags), .rsp1_flags(rsp1_flags)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        port;
    logic [31:0] res;
    logic [3:0]  flg;
  } exp_t;
  exp_t exp_q[$];
  logic ptr_m;
  logic [1:0] drop;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Drive point: just after a rising edge; sample point: the falling edge
  task automatic nxt();
    @(posedge clk);
    #2;
  endtask

  task automatic smp();
    #3;
  endtask

  function automatic logic [31:0] model_res(input logic o, input logic [31:0] x, input logic [31:0] y);
    return o ? x - y : x + y;
  endfunction

  function automatic logic [3:0] model_flg(input logic o, input logic [31:0] x, input logic [31:0] y);
    logic [31:0] r;
    logic        c, v;
    longint      sr;
    r = model_res(o, x, y);
    if (o) begin
      c  = (x >= y);
      sr = longint'(signed'(x)) - longint'(signed'(y));
    end else begin
      c  = ({1'b0, x} + {1'b0, y}) > 33'h0_FFFF_FFFF;
      sr = longint'(signed'(x)) + longint'(signed'(y));
    end
    v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    return {c, v, r[31], (r == 32'd0)};
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 4))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic set_req(input int p, input logic o, input logic [31:0] x, input logic [31:0] y);
    vld[p] = 1'b1;
    op[p]  = o;
    a[p]   = x;
    b[p]   = y;
  endtask

  // One randomized cycle: drive, then check against the transaction model
  task automatic rnd_cycle(input bit gen);
    exp_t e;
    nxt();
    for (int p = 0; p < 2; p++) begin
      if (drop[p]) begin
        vld[p]  = 1'b0;
        drop[p] = 1'b0;
      end
      if (gen && !vld[p] && $urandom_range(0, 2) == 0)
        set_req(p, 1'($urandom), pick(), pick());
    end
    rspr = gen ? 2'($urandom) : 2'b11;
    smp();
    chk1("rnd_ready_legal", (rdy == 2'b11) || ((rdy & ~vld) != 2'b00), 1'b0);
    for (int p = 0; p < 2; p++) begin
      if (rspv[p]) begin
        chk1("rnd_rsp_expected", (exp_q.size() != 0) && (exp_q[0].port == 1'(p)), 1'b1);
        if (exp_q.size() != 0) begin
          chk("rnd_rsp_data", dat[p], exp_q[0].res);
`ifdef ADDSUB_ARB_FLAGS_EN
          chk("rnd_rsp_flags", 32'(p == 0 ? rsp0_flags : rsp1_flags), 32'(exp_q[0].flg));
`endif
          if (rspr[p]) begin
            void'(exp_q.pop_front());
            ptr_m = ~1'(p);
          end
        end
      end
    end
    for (int p = 0; p < 2; p++) begin
      if (vld[p] && rdy[p]) begin
        chk1("rnd_single_inflight", exp_q.size() == 0, 1'b1);
        if (vld == 2'b11) chk1("rnd_grant_rr", 1'(p), ptr_m);
        e.port = 1'(p);
        e.res  = model_res(op[p], a[p], b[p]);
        e.flg  = model_flg(op[p], a[p], b[p]);
        exp_q.push_back(e);
        drop[p] = 1'b1;
      end
    end
  endtask

  logic [31:0] t3a [3];
  logic [31:0] t3b [3];
  logic        t3o [3];

  initial begin
    rst  = 1'b1;
    vld  = 2'b00;
    op   = 2'b00;
    rspr = 2'b00;
    a    = '0;
    b    = '0;
    drop = 2'b00;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    smp();

    // Reset state
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_req0_ready", req0_ready, 1'b0);
    chk1("rst_req1_ready", req1_ready, 1'b0);
    chk1("rst_rsp0_valid", rsp0_valid, 1'b0);
    chk1("rst_rsp1_valid", rsp1_valid, 1'b0);
    chk("rst_rsp0_data", rsp0_data, 32'h0);

    // Single add on port 0, 5+3, latency and busy window
    nxt();
    set_req(0, 1'b0, 32'd5, 32'd3);
    rspr[0] = 1'b1;
    smp();
    chk1("t1_req0_ready", req0_ready, 1'b1);
    chk1("t1_req1_ready", req1_ready, 1'b0);
    chk1("t1_idle_busy", busy, 1'b0);
    nxt();
    vld[0] = 1'b0;
    smp();
    chk1("t1_exec_busy", busy, 1'b1);
    chk1("t1_exec_rsp0_valid", rsp0_valid, 1'b0);
    chk("t1_exec_rsp0_data", rsp0_data, 32'h0);
    nxt();
    smp();
    chk1("t1_resp_rsp0_valid", rsp0_valid, 1'b1);
    chk("t1_resp_rsp0_data", rsp0_data, 32'h0000_0008);
    chk1("t1_resp_busy", busy, 1'b1);
    chk1("t1_resp_rsp1_valid", rsp1_valid, 1'b0);
    nxt();
    smp();
    chk1("t1_done_busy", busy, 1'b0);
    chk1("t1_done_rsp0_valid", rsp0_valid, 1'b0);

    // Simultaneous requests after reset: pointer (port 0) wins, port 1 next
    nxt();
    rst = 1'b1;
    #1;
    rst = 1'b0;
    set_req(0, 1'b1, 32'd10, 32'd3);
    set_req(1, 1'b0, 32'hFFFF_FFFF, 32'd1);
    rspr = 2'b11;
    smp();
    chk1("t2_req0_ready", req0_ready, 1'b1);
    chk1("t2_req1_ready_idle", req1_ready, 1'b0);
    nxt();
    vld[0] = 1'b0;
    smp();
    chk1("t2_req1_ready_exec", req1_ready, 1'b0);
    nxt();
    smp();
    chk("t2_rsp0_data", rsp0_data, 32'h0000_0007);
    chk1("t2_req1_ready_resp", req1_ready, 1'b0);
    nxt();
    smp();
    chk1("t2_req1_ready_next", req1_ready, 1'b1);
    nxt();
    vld[1] = 1'b0;
    nxt();
    smp();
    chk1("t2_rsp1_valid", rsp1_valid, 1'b1);
    chk("t2_rsp1_data", rsp1_data, 32'h0000_0000);

    // Port 1 alone, three back-to-back operations, one every 3 cycles
    for (int k = 0; k < 3; k++) begin
      t3a[k] = pick();
      t3b[k] = pick();
      t3o[k] = 1'($urandom);
    end
    nxt();
    set_req(1, t3o[0], t3a[0], t3b[0]);
    for (int k = 0; k < 3; k++) begin
      smp();
      chk1("t3_accept", req1_ready, 1'b1);
      nxt();
      if (k < 2) set_req(1, t3o[k+1], t3a[k+1], t3b[k+1]);
      else       vld[1] = 1'b0;
      smp();
      chk1("t3_exec_ready", req1_ready, 1'b0);
      nxt();
      smp();
      chk1("t3_rsp_valid", rsp1_valid, 1'b1);
      chk("t3_rsp_data", rsp1_data, model_res(t3o[k], t3a[k], t3b[k]));
      nxt();
    end

    // Port 0 response back-pressured 5 cycles while port 1 waits
    rspr = 2'b00;
    set_req(0, 1'b1, 32'd0, 32'd1);
    smp();
    chk1("t4_req0_ready", req0_ready, 1'b1);
    nxt();
    vld[0] = 1'b0;
    set_req(1, 1'b0, 32'd3, 32'd4);
    rspr[0] = 1'b1;   // early ready must be ignored during EXEC
    smp();
    chk1("t4_exec_req1_ready", req1_ready, 1'b0);
    nxt();
    rspr[0] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      smp();
      chk1("t4_hold_valid", rsp0_valid, 1'b1);
      chk("t4_hold_data", rsp0_data, 32'hFFFF_FFFF);
      chk1("t4_hold_req1_ready", req1_ready, 1'b0);
      nxt();
    end
    rspr[0] = 1'b1;
    smp();
    chk1("t4_release_valid", rsp0_valid, 1'b1);
    nxt();
    rspr[0] = 1'b0;
    smp();
    chk1("t4_idle_busy", busy, 1'b0);
    chk1("t4_idle_req1_ready", req1_ready, 1'b1);
    nxt();
    vld[1]  = 1'b0;
    rspr[1] = 1'b1;
    nxt();
    smp();
    chk("t4_rsp1_data", rsp1_data, 32'd7);
    nxt();
    rspr = 2'b00;

    // Asynchronous reset during EXEC
    set_req(1, 1'b0, 32'd9, 32'd9);
    smp();
    chk1("t5_req1_ready", req1_ready, 1'b1);
    nxt();
    vld[1] = 1'b0;
    smp();
    chk1("t5_exec_busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    chk1("t5_exec_rst_busy", busy, 1'b0);
    chk1("t5_exec_rst_rsp1", rsp1_valid, 1'b0);
    nxt();
    rst = 1'b0;
    rspr = 2'b11;
    smp();
    chk1("t5_no_rsp1", rsp1_valid, 1'b0);

    // Asynchronous reset during RESP
    nxt();
    rspr = 2'b00;
    set_req(0, 1'b0, 32'd1, 32'd1);
    smp();
    nxt();
    vld[0] = 1'b0;
    nxt();
    smp();
    chk1("t5_resp_valid", rsp0_valid, 1'b1);
    rst = 1'b1;
    #1;
    chk1("t5_resp_rst_valid", rsp0_valid, 1'b0);
    chk("t5_resp_rst_data", rsp0_data, 32'h0);
    chk1("t5_resp_rst_busy", busy, 1'b0);
    nxt();
    rst  = 1'b0;
    rspr = 2'b11;
    smp();
    chk1("t5_no_rsp0", rsp0_valid, 1'b0);
    nxt();
    set_req(0, 1'b1, 32'h8000_0000, 32'd1);
    set_req(1, 1'b0, 32'd2, 32'd2);
    smp();
    chk1("t5_ptr_port0", req0_ready, 1'b1);
    chk1("t5_ptr_port1", req1_ready, 1'b0);
    nxt();
    vld[0] = 1'b0;
    nxt();
    smp();
    chk("t5_after_rst_data", rsp0_data, 32'h7FFF_FFFF);
    nxt();
    smp();
    chk1("t5_port1_next", req1_ready, 1'b1);
    nxt();
    vld[1] = 1'b0;
    nxt();
    smp();
    chk("t5_port1_data", rsp1_data, 32'd4);
    nxt();

`ifdef ADDSUB_ARB_FLAGS_EN
    // Flags: signed overflow case, then zero/no-borrow case
    set_req(0, 1'b0, 32'h7FFF_FFFF, 32'd1);
    smp();
    nxt();
    vld[0] = 1'b0;
    smp();
    chk("t6_flags_idle", 32'(rsp0_flags), 32'h0);
    nxt();
    smp();
    chk("t6_flags_ovf", 32'(rsp0_flags), 32'b0110);
    nxt();
    set_req(0, 1'b1, 32'd5, 32'd5);
    smp();
    nxt();
    vld[0] = 1'b0;
    nxt();
    smp();
    chk("t6_flags_zero", 32'(rsp0_flags), 32'b1001);
    chk("t6_flags_port1", 32'(rsp1_flags), 32'h0);
    nxt();
`endif

    // Randomized traffic against the transaction model
    rspr = 2'b00;
    rst  = 1'b1;
    #1;
    rst  = 1'b0;
    ptr_m = 1'b0;
    exp_q.delete();
    for (int c = 0; c < 600; c++) rnd_cycle(1'b1);
    for (int c = 0; c < 24; c++)  rnd_cycle(1'b0);
    chk("rnd_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/addsub_arbiter.md
Name: addsub_arbiter

Overview:
- Shares one 32-bit add/subtract datapath between two requesters (port 0, port 1).
- Each port uses a valid/ready request channel and a valid/ready response channel.
- Arbitration is round-robin, and only one operation is in flight at a time.
- Sits between the instruction/issue logic and the ALU add/sub path.

Parameters:
- WIDTH, 32, operand and result width in bits.

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- req0_valid  input  1  port 0 request valid
- req0_ready  output  1  port 0 request accepted this cycle when high with req0_valid
- req0_op  input  1  port 0 operation: 0 = a+b, 1 = a-b
- req0_a  input  WIDTH  port 0 operand a
- req0_b  input  WIDTH  port 0 operand b
- rsp0_valid  output  1  port 0 result valid
- rsp0_ready  input  1  port 0 consumer ready
- rsp0_data  output  WIDTH  port 0 result
- req1_valid, req1_ready, req1_op, req1_a, req1_b, rsp1_valid, rsp1_ready, rsp1_data: same as port 0, for port 1
- busy  output  1  high whenever state is not IDLE

Behaviour:
- Reset (asynchronous, active high):
  - state = IDLE, priority pointer = port 0, owner = 0.
  - Operand and result registers = 0.
  - All rsp*_valid = 0, busy = 0, req*_ready = 0.
  - Reset mid-operation aborts the operation; no response is issued.
- States: IDLE, EXEC, RESP.
- IDLE:
  - Grant goes to the pointer port if it is valid, else to the other port if valid.
  - reqN_ready = 1 only for the granted port. It is combinational from state and the valid inputs; the non-granted port sees 0.
  - On accept (valid & ready): latch op, a, b and owner; go to EXEC.
  - No valid request: stay in IDLE.
- EXEC (exactly one cycle):
  - Result register <= a + b, or a + (~b) + 1 for subtract; arithmetic is modulo 2^WIDTH.
  - Carry-out is discarded in the base build.
  - Go to RESP.
- RESP:
  - rsp<owner>_valid = 1 and rsp<owner>_data = result register; the other port's rsp_valid = 0.
  - Valid and data stay stable until rsp<owner>_ready is sampled high.
  - On that edge: go to IDLE and set pointer = ~owner, so the other port has priority next.
  - Requests presented in EXEC or RESP are not accepted (ready = 0) and must be held by the requester.
- Latency:
  - Accept edge at cycle N, rsp_valid high in cycle N+2 at the earliest.
  - With rsp_ready tied high, throughput is one operation per 3 cycles.
- rsp*_data reads 0 on a port that is not in RESP.
- Simultaneous requests: pointer wins, and the loser is served next.
- Single requester: served back-to-back regardless of pointer.
- rsp_ready asserted early (before RESP) is ignored.
- Boundary arithmetic:
  - 0xFFFFFFFF + 1 = 0x00000000.
  - 0 - 1 = 0xFFFFFFFF.
  - 0x80000000 - 1 = 0x7FFFFFFF.

Optional Feature:
- Macro ADDSUB_ARB_FLAGS_EN.
- When defined, adds output ports rsp0_flags and rsp1_flags, each 4 bits: {carry, overflow, negative, zero}. They are computed in EXEC and registered with the result.
  - carry = bit WIDTH of the extended sum; for subtract it means "no borrow".
  - overflow = signed overflow.
  - negative = result MSB.
  - zero = result == 0.
- Flags are valid only with rsp_valid, else 0; reset value is 0.
- When undefined, these ports and registers do not exist and behaviour is otherwise identical.

Test Plan:
- Reset then port 0 add 5+3 with rsp0_ready=1 -> req0_ready=1 in IDLE; rsp0_valid in cycle N+2 with data 0x00000008; busy high for 2 cycles.
- Both ports valid at once after reset: port 0 sub 10-3, port 1 add 0xFFFFFFFF+1 -> port 0 served first (0x00000007), then port 1 (0x00000000); req1_ready=0 until port 0 response completes.
- Port 1 issues three back-to-back requests with port 0 idle -> all three served consecutively, 3 cycles each, correct results in order.
- Port 0 response with rsp0_ready held low 5 cycles, 0-1 -> rsp0_valid and data 0xFFFFFFFF held stable for all 5 cycles; IDLE one cycle after ready rises; port 1 request meanwhile stalls with req1_ready=0.
- Assert rst during EXEC, then during RESP -> outputs return to reset values immediately (asynchronously); no response appears; next request after reset is handled normally with pointer at port 0.
- With ADDSUB_ARB_FLAGS_EN defined: 0x7FFFFFFF+1 -> flags {0,1,1,0}; 5-5 -> flags {1,0,0,1}.
